// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: merges the instruction-fetch and data-access sram-like
// request ports onto one shared downstream sram-like port, and routes each
// in-order response back to whichever port issued the matching request.
//
// Optional feature macro: SRAM_ARB_RR_EN
//   defined   -> round-robin arbitration between the two ports in IDLE
//   undefined -> fixed priority, data port beats instruction port
module sram_bus_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int CNT_W       = 2
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch port
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  // data-access port
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  // shared response data
  output logic [31:0] rdata,
  // downstream port toward the bus bridge
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  // status
  output logic        busy,
  output logic        err_data_ok
);

  // A single-entry FIFO still needs a one-bit pointer; it simply never moves.
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OUTSTANDING-1:0] id_fifo;
  logic               err_q;

  logic               full;
  logic               empty;
  logic               own_valid;
  logic               own_data;
  logic               own_req;
  logic               grant_req;
  logic               accept;
  logic               pop;
  logic               head_data;

`ifdef SRAM_ARB_RR_EN
  // High means the instruction port wins the next two-way conflict.
  logic               prio_inst;
`endif

  // Pointer advance with wrap at the FIFO depth (depth need not fill PTR_W).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (OUTSTANDING == 1) return '0;
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(OUTSTANDING));
  assign empty     = (count == '0);
  assign head_data = id_fifo[rd_ptr];

  // Pick the owner of the downstream port: free choice in IDLE, locked in HOLD.
  always_comb begin
    own_valid = 1'b0;
    own_data  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!full) begin
`ifdef SRAM_ARB_RR_EN
          if (i_req && d_req) begin
            own_valid = 1'b1;
            own_data  = ~prio_inst;
          end else if (d_req) begin
            own_valid = 1'b1;
            own_data  = 1'b1;
          end else if (i_req) begin
            own_valid = 1'b1;
            own_data  = 1'b0;
          end
`else
          if (d_req) begin
            own_valid = 1'b1;
            own_data  = 1'b1;
          end else if (i_req) begin
            own_valid = 1'b1;
            own_data  = 1'b0;
          end
`endif
        end
      end
      HOLD_I: begin
        own_valid = 1'b1;
        own_data  = 1'b0;
      end
      HOLD_D: begin
        own_valid = 1'b1;
        own_data  = 1'b1;
      end
      default: begin
        own_valid = 1'b0;
        own_data  = 1'b0;
      end
    endcase
  end

  assign own_req   = own_data ? d_req : i_req;
  assign grant_req = own_valid & own_req & ~full;
  assign accept    = grant_req & m_addr_ok;
  assign pop       = m_data_ok & ~empty;

  // Next-state: stall in HOLD until accepted, bail out if the owner withdraws.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_req && !m_addr_ok) begin
          state_next = own_data ? HOLD_D : HOLD_I;
        end
      end
      HOLD_I, HOLD_D: begin
        if (accept || !own_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outstanding count: push and pop in the same cycle cancel out.
  always_comb begin
    count_next = count;
    unique case ({accept, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // State, count and FIFO pointers; reset drops any in-flight bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // ID FIFO storage: records which port owns each accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_fifo <= '0;
    end else if (accept) begin
      id_fifo[wr_ptr] <= own_data;
    end
  end

  // Sticky error when the bridge answers with nothing outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (m_data_ok && empty) begin
      err_q <= 1'b1;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Round-robin pointer moves only on a real accept, favouring the other port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_inst <= 1'b1;
    end else if (accept) begin
      prio_inst <= own_data;
    end
  end
`endif

  // Downstream request fields follow the owner; zero when nobody owns the bus.
  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'b00;
    m_wstrb = 4'b0000;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if (own_valid && !reset) begin
      if (own_data) begin
        m_wr    = d_wr;
        m_size  = d_size;
        m_wstrb = d_wstrb;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end else begin
        m_wr    = i_wr;
        m_size  = i_size;
        m_wstrb = i_wstrb;
        m_addr  = i_addr;
        m_wdata = i_wdata;
      end
    end
  end

  // Handshake and status outputs are forced low while reset is held.
  assign m_req       = ~reset & grant_req;
  assign i_addr_ok   = ~reset & accept & ~own_data;
  assign d_addr_ok   = ~reset & accept & own_data;
  assign i_data_ok   = ~reset & pop & ~head_data;
  assign d_data_ok   = ~reset & pop & head_data;
  assign rdata       = (~reset & pop) ? m_rdata : 32'h0;
  assign busy        = ~reset & ((count != '0) | (state != IDLE));
  assign err_data_ok = ~reset & err_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: scenario-driven bench for sram_bus_arbiter. Expected
// response owners are queued as requests are accepted and popped when the
// bridge answers.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_wr;
  logic [1:0]  i_size;
  logic [3:0]  i_wstrb;
  logic [31:0] i_addr, i_wdata;
  logic        i_addr_ok, i_data_ok;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        busy, err_data_ok;

  int checks;
  int errors;
  bit exp_q[$];
  bit prio_inst_m;

  sram_bus_arbiter #(.OUTSTANDING(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .rdata(rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy), .err_data_ok(err_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not end in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    i_req = 0; i_wr = 0; i_size = 2'd2; i_wstrb = 4'h0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 2'd2; d_wstrb = 4'h0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  // Arbitration model: who wins when the given ports request in IDLE.
  function automatic bit model_winner_data(input bit ireq, input bit dreq);
`ifdef SRAM_ARB_RR_EN
    if (ireq && dreq) return ~prio_inst_m;
`endif
    return dreq;
  endfunction

  task automatic model_accept(input bit is_data);
    exp_q.push_back(is_data);
    prio_inst_m = is_data;
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_req = 1; d_req = 1; i_addr = 32'h1C00_0000; d_addr = 32'h0000_1000;
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, busy, err_data_ok} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl_zero: got %b expected 0000000",
               {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, busy, err_data_ok});
    end
    checks++;
    if (m_addr !== 32'h0 || rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data_zero: got m_addr=%h rdata=%h expected 0", m_addr, rdata);
    end
    @(negedge clk);
    clear_inputs();
    reset = 0;
    exp_q.delete();
    prio_inst_m = 1;
    #1;
    checks++;
    if (busy !== 1'b0 || err_data_ok !== 1'b0 || m_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: got busy=%b err=%b m_req=%b expected 0 0 0",
               busy, err_data_ok, m_req);
    end
  endtask

  task automatic test_single_read();
    bit exp_id;
    @(negedge clk);
    clear_inputs();
    i_req = 1; i_addr = 32'h1C00_0000; m_addr_ok = 1;
    #1;
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h1C00_0000) begin
      errors++;
      $display("[TB] FAIL single_grant: got m_req=%b m_addr=%h expected 1 1c000000", m_req, m_addr);
    end
    checks++;
    if ({i_addr_ok, d_addr_ok} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL single_addr_ok: got %b%b expected 10", i_addr_ok, d_addr_ok);
    end
    model_accept(0);
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_busy: got %b expected 1", busy);
    end
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'h02C0_0000;
    #1;
    exp_id = exp_q.pop_front();
    checks++;
    if ({i_data_ok, d_data_ok} !== {~exp_id, exp_id} || rdata !== 32'h02C0_0000) begin
      errors++;
      $display("[TB] FAIL single_resp: got i/d=%b%b rdata=%h expected %b%b 02c00000",
               i_data_ok, d_data_ok, rdata, ~exp_id, exp_id);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (busy !== 1'b0 || err_data_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: got busy=%b err=%b expected 0 0", busy, err_data_ok);
    end
  endtask

  task automatic test_conflict();
    bit win_data, exp_id;
    logic [31:0] ia, da, exp_a, rd;
    for (int r = 0; r < 2; r++) begin
      ia = 32'h1C00_0040 + 32'(r * 16);
      da = 32'h0000_1000 + 32'(r * 4);
      @(negedge clk);
      clear_inputs();
      i_req = 1; i_addr = ia;
      d_req = 1; d_wr = 1; d_wstrb = 4'hF; d_addr = da; d_wdata = 32'hCAFE_0000 + 32'(r);
      m_addr_ok = 1;
      #1;
      win_data = model_winner_data(1'b1, 1'b1);
      exp_a = win_data ? da : ia;
      checks++;
      if (m_addr !== exp_a || m_wr !== win_data) begin
        errors++;
        $display("[TB] FAIL conflict_first: got m_addr=%h m_wr=%b expected %h %b", m_addr, m_wr, exp_a, win_data);
      end
      checks++;
      if ({i_addr_ok, d_addr_ok} !== {~win_data, win_data}) begin
        errors++;
        $display("[TB] FAIL conflict_first_ok: got %b%b expected %b%b", i_addr_ok, d_addr_ok, ~win_data, win_data);
      end
      model_accept(win_data);
      @(negedge clk);
      if (win_data) d_req = 0; else i_req = 0;
      #1;
      exp_a = win_data ? ia : da;
      checks++;
      if (m_addr !== exp_a || {i_addr_ok, d_addr_ok} !== {win_data, ~win_data}) begin
        errors++;
        $display("[TB] FAIL conflict_second: got m_addr=%h ok=%b%b expected %h %b%b",
                 m_addr, i_addr_ok, d_addr_ok, exp_a, win_data, ~win_data);
      end
      model_accept(~win_data);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        clear_inputs();
        rd = 32'h5500_0000 + 32'(r * 2 + k);
        m_data_ok = 1; m_rdata = rd;
        #1;
        exp_id = exp_q.pop_front();
        checks++;
        if ({i_data_ok, d_data_ok} !== {~exp_id, exp_id} || rdata !== rd) begin
          errors++;
          $display("[TB] FAIL conflict_resp: got i/d=%b%b rdata=%h expected %b%b %h",
                   i_data_ok, d_data_ok, rdata, ~exp_id, exp_id, rd);
        end
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_hold_lock();
    bit exp_id;
    logic [31:0] da;
    da = 32'h0000_2000;
    @(negedge clk);
    clear_inputs();
    d_req = 1; d_addr = da;
    #1;
    checks++;
    if (m_req !== 1'b1 || m_addr !== da || d_addr_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_grant: got m_req=%b m_addr=%h d_addr_ok=%b expected 1 %h 0", m_req, m_addr, d_addr_ok, da);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      i_req = 1; i_addr = 32'h1C00_0100;
      #1;
      checks++;
      if (m_req !== 1'b1 || m_addr !== da || {i_addr_ok, d_addr_ok} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL hold_locked: got m_req=%b m_addr=%h ok=%b%b expected 1 %h 00",
                 m_req, m_addr, i_addr_ok, d_addr_ok, da);
      end
    end
    @(negedge clk);
    m_addr_ok = 1;
    #1;
    checks++;
    if (m_addr !== da || {i_addr_ok, d_addr_ok} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL hold_accept: got m_addr=%h ok=%b%b expected %h 01", m_addr, i_addr_ok, d_addr_ok, da);
    end
    model_accept(1);
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if ({i_addr_ok, d_addr_ok} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL hold_pulse_once: got %b%b expected 00", i_addr_ok, d_addr_ok);
    end
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'h7777_0001;
    #1;
    exp_id = exp_q.pop_front();
    checks++;
    if ({i_data_ok, d_data_ok} !== {~exp_id, exp_id} || rdata !== 32'h7777_0001) begin
      errors++;
      $display("[TB] FAIL hold_resp: got i/d=%b%b rdata=%h expected %b%b 77770001",
               i_data_ok, d_data_ok, rdata, ~exp_id, exp_id);
    end
    // owner withdraws while stalled: no entry may be recorded
    @(negedge clk);
    clear_inputs();
    i_req = 1; i_addr = 32'h1C00_0200;
    #1;
    checks++;
    if (m_req !== 1'b1 || i_addr_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_grant: got m_req=%b i_addr_ok=%b expected 1 0", m_req, i_addr_ok);
    end
    @(negedge clk);
    i_req = 0;
    #1;
    checks++;
    if (m_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_hold: got m_req=%b busy=%b expected 0 1", m_req, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_no_push: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_fifo_full();
    bit exp_id;
    logic [31:0] rd;
    @(negedge clk);
    clear_inputs();
    i_req = 1; i_addr = 32'h1C00_0300; m_addr_ok = 1;
    #1;
    checks++;
    if ({i_addr_ok, d_addr_ok} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL full_acc_inst: got %b%b expected 10", i_addr_ok, d_addr_ok);
    end
    model_accept(0);
    @(negedge clk);
    i_req = 0; d_req = 1; d_addr = 32'h0000_3000;
    #1;
    checks++;
    if ({i_addr_ok, d_addr_ok} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL full_acc_data: got %b%b expected 01", i_addr_ok, d_addr_ok);
    end
    model_accept(1);
    @(negedge clk);
    d_req = 0; i_req = 1; i_addr = 32'h1C00_0304;
    #1;
    checks++;
    if (m_req !== 1'b0 || i_addr_ok !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_block: got m_req=%b i_addr_ok=%b busy=%b expected 0 0 1", m_req, i_addr_ok, busy);
    end
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'h1111_0000;
    #1;
    checks++;
    if (m_req !== 1'b0 || i_addr_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_block_on_pop: got m_req=%b i_addr_ok=%b expected 0 0", m_req, i_addr_ok);
    end
    exp_id = exp_q.pop_front();
    checks++;
    if ({i_data_ok, d_data_ok} !== {~exp_id, exp_id} || rdata !== 32'h1111_0000) begin
      errors++;
      $display("[TB] FAIL full_resp1: got i/d=%b%b rdata=%h expected %b%b 11110000",
               i_data_ok, d_data_ok, rdata, ~exp_id, exp_id);
    end
    @(negedge clk);
    m_data_ok = 0;
    #1;
    checks++;
    if (m_req !== 1'b1 || i_addr_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_retry: got m_req=%b i_addr_ok=%b expected 1 1", m_req, i_addr_ok);
    end
    model_accept(0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      clear_inputs();
      rd = 32'h2222_0000 + 32'(k);
      m_data_ok = 1; m_rdata = rd;
      #1;
      exp_id = exp_q.pop_front();
      checks++;
      if ({i_data_ok, d_data_ok} !== {~exp_id, exp_id} || rdata !== rd) begin
        errors++;
        $display("[TB] FAIL full_drain: got i/d=%b%b rdata=%h expected %b%b %h",
                 i_data_ok, d_data_ok, rdata, ~exp_id, exp_id, rd);
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_id, is_d;
    logic [31:0] a, rd;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      clear_inputs();
      is_d = k[0];
      a = (is_d ? 32'h0000_4000 : 32'h1C00_4000) + 32'(k * 4);
      if (k < 6) begin
        if (is_d) begin d_req = 1; d_addr = a; end
        else begin i_req = 1; i_addr = a; end
        m_addr_ok = 1;
      end
      rd = 32'hB000_0000 + 32'(k);
      if (k > 0) begin
        m_data_ok = 1; m_rdata = rd;
      end
      #1;
      if (k < 6) begin
        checks++;
        if (m_addr !== a || {i_addr_ok, d_addr_ok} !== {~is_d, is_d}) begin
          errors++;
          $display("[TB] FAIL b2b_accept[%0d]: got m_addr=%h ok=%b%b expected %h %b%b",
                   k, m_addr, i_addr_ok, d_addr_ok, a, ~is_d, is_d);
        end
        model_accept(is_d);
      end
      if (k > 0) begin
        exp_id = exp_q.pop_front();
        checks++;
        if ({i_data_ok, d_data_ok} !== {~exp_id, exp_id} || rdata !== rd) begin
          errors++;
          $display("[TB] FAIL b2b_resp[%0d]: got i/d=%b%b rdata=%h expected %b%b %h",
                   k, i_data_ok, d_data_ok, rdata, ~exp_id, exp_id, rd);
        end
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (busy !== 1'b0 || err_data_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got busy=%b err=%b expected 0 0", busy, err_data_ok);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    clear_inputs();
    i_req = 1; i_addr = 32'h1C00_5000; m_addr_ok = 1;
    #1;
    model_accept(0);
    @(negedge clk);
    i_req = 0; d_req = 1; d_addr = 32'h0000_5000;
    #1;
    model_accept(1);
    @(negedge clk);
    reset = 1;
    i_req = 1; d_req = 1; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h3333_3333;
    #1;
    checks++;
    if ({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, busy} !== 6'b0 || m_addr !== 32'h0 || rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_zero: got ctrl=%b m_addr=%h rdata=%h expected 000000 0 0",
               {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, busy}, m_addr, rdata);
    end
    exp_q.delete();
    prio_inst_m = 1;
    @(negedge clk);
    clear_inputs();
    reset = 0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_release: got busy=%b expected 0", busy);
    end
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'h4444_4444;
    #1;
    checks++;
    if ({i_data_ok, d_data_ok} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL stray_no_data_ok: got %b%b expected 00", i_data_ok, d_data_ok);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (err_data_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stray_err_set: got %b expected 1", err_data_ok);
    end
    @(negedge clk);
    #1;
    checks++;
    if (err_data_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stray_err_sticky: got %b expected 1", err_data_ok);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prio_inst_m = 1;
    reset = 1;
    clear_inputs();
    $display("[TB] starting sram_bus_arbiter bench");
    test_reset();
    test_single_read();
    test_conflict();
    test_hold_lock();
    test_fifo_full();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Arbitrates the instruction-fetch and data-access sram-like request ports onto one shared downstream sram-like port (toward the AXI bridge).
- Tracks the owner of every accepted request in an in-order ID FIFO and routes each returning data_ok/rdata to the correct requester.
- Sits between the IF/EX/MEM stage memory interfaces and the bus bridge.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered requests (ID FIFO depth, power of two, ≥1).
- CNT_W, 2, width of the outstanding counter; must hold 0..OUTSTANDING.

Ports:
- clk input 1: clock, rising edge.
- reset input 1: asynchronous, active-high reset.
- i_req input 1: inst port request.
- i_wr input 1: inst port write flag.
- i_size input 2: inst port size.
- i_wstrb input 4: inst port byte strobe.
- i_addr input 32: inst port address.
- i_wdata input 32: inst port write data.
- i_addr_ok output 1: inst port request accepted.
- i_data_ok output 1: inst port response valid.
- d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata: inputs, same widths as inst port, data-access port.
- d_addr_ok, d_data_ok output 1 each: data port accept/response.
- rdata output 32: response data, shared by both ports, valid with i_data_ok/d_data_ok.
- m_req output 1: downstream request.
- m_wr, m_size, m_wstrb, m_addr, m_wdata: outputs, same widths, muxed from the owner.
- m_addr_ok input 1: downstream accept.
- m_data_ok input 1: downstream response.
- m_rdata input 32: downstream read data.
- busy output 1: outstanding count nonzero or state not IDLE.
- err_data_ok output 1: sticky flag, m_data_ok seen with empty FIFO.

Behaviour:
- States: IDLE, HOLD_I, HOLD_D. Reset puts the block in IDLE, FIFO empty, count 0, err_data_ok 0, round-robin pointer pointing to inst.
- While reset is high, all outputs are 0.
- Arbitration happens only in IDLE and is combinational. Default priority: d_req beats i_req. The winner drives the m_* fields the same cycle.
- Full rule: if count==OUTSTANDING, m_req=0 and no grant is issued. This holds even when m_data_ok pops in the same cycle; the grant is retried next cycle.
- m_req = owner req & ~full. The m_* fields are muxed from the owner; when there is no owner they are 0.
- Accept (m_req & m_addr_ok):
  - Push owner ID (0=inst, 1=data) into the FIFO.
  - Pulse the owner's *_addr_ok combinationally in the same cycle.
  - Next state is IDLE.
- Grant without m_addr_ok: go to HOLD_I/HOLD_D. The owner is locked and the other port is ignored until accept, so the sram-like request stays stable.
- If the owner drops req while in HOLD (protocol violation), return to IDLE next cycle with no push.
- Response (m_data_ok & FIFO nonempty):
  - Pop the head ID.
  - Assert that ID's *_data_ok combinationally, with rdata=m_rdata.
  - In-order return only.
- m_data_ok with FIFO empty: no *_data_ok, err_data_ok set to 1 and held until reset.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo OUTSTANDING.
- Non-owner *_addr_ok is always 0. Both *_data_ok are never high in the same cycle.
- Latency: grant-to-m_req is 0 cycles. m_data_ok-to-*_data_ok is 0 cycles. The block adds no pipeline registers on the data path.
- Asynchronous reset mid-transaction discards the FIFO contents and HOLD state immediately. Later stray m_data_ok sets err_data_ok.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration in IDLE. When both ports request, the port not granted last wins. The pointer updates only on accept (m_addr_ok), not on a HOLD entry.
- Undefined: fixed priority, data over inst. No pointer register.

Test Plan:
- Single inst read: i_req=1, i_addr=0x1C000000, m_addr_ok=1 same cycle.
  - Required: m_addr=0x1C000000 and i_addr_ok=1 that cycle.
  - Two cycles later m_data_ok=1, m_rdata=0x02C00000 → i_data_ok=1, rdata=0x02C00000, d_data_ok=0.
- Conflict, fixed priority: i_req and d_req both 1, d_addr=0x00001000, d_wr=1, d_wstrb=0xF.
  - Required: data granted first (m_wr=1, m_addr=0x1000), inst granted next accept.
  - With SRAM_ARB_RR_EN and last grant = data: inst wins first instead.
- Hold lock: d_req granted, m_addr_ok held 0 for 3 cycles while i_req rises.
  - Required: m_addr stays at d_addr, i_addr_ok=0 throughout.
  - d_addr_ok pulses once when m_addr_ok=1.
- FIFO full (OUTSTANDING=2): accept inst then data with no responses.
  - Third request → m_req=0.
  - First m_data_ok → i_data_ok. The next cycle m_req=1 again.
  - Second m_data_ok → d_data_ok.
- Push+pop same cycle at count=1: count stays 1, and response ordering is preserved across pointer wrap over 6 back-to-back transactions.
- Reset mid-flight: reset=1 with 2 outstanding.
  - Required: busy=0 and all outputs 0 immediately.
  - A later m_data_ok after reset release → err_data_ok=1, no *_data_ok.
